// File: rtl/mem_access_unit.sv
// Load/store unit: sizes and aligns CPU accesses onto a req/ack word bus,
// stalls the CPU while a request is outstanding and flags bus timeouts.

module mem_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] L = LANE[1:0];

  always_comb begin
    be    = 1'b1;
    wbyte = wdata[8*LANE +: 8];
    case (size)
      2'b00: begin
        be    = (addr_lo == L);
        wbyte = wdata[7:0];
      end
      2'b01: begin
        be    = (addr_lo[1] == L[1]);
        wbyte = L[0] ? wdata[15:8] : wdata[7:0];
      end
      default: ;
    endcase
  end
endmodule

module mem_access_unit #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);
  localparam int NUM_LANES = 4;
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  // What the load path needs to remember about the accepted access
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sign;
    logic [1:0] lo;
  } req_t;

  state_t                           state, state_n;
  req_t                             req_q;
  logic [TIMEOUT_W-1:0]             cnt;
  logic [NUM_LANES-1:0]             be_c;
  logic [NUM_LANES-1:0][7:0]        wd_c;
  logic                             valid, mis, accept;
  logic [7:0]                       ld_b;
  logic [15:0]                      ld_h;
  logic [31:0]                      ld_val;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      mem_lane #(.LANE(i)) u_lane (
        .size    (mem_size),
        .addr_lo (addr[1:0]),
        .wdata   (wdata),
        .be      (be_c[i]),
        .wbyte   (wd_c[i])
      );
    end
  endgenerate

  assign valid  = cpu_en & (mem_r | mem_w);
  assign mis    = ((mem_size == 2'b01) & addr[0]) | (mem_size[1] & (|addr[1:0]));
  assign accept = (state == IDLE) & valid & ~mis;

  always_comb begin
    state_n  = state;
    stall    = 1'b0;
    misalign = 1'b0;
    case (state)
      IDLE: if (valid) begin
        if (mis) misalign = 1'b1;
        else begin
          stall   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        // ack beats a coincident timeout
        if (bus_ack)              state_n = DONE;
        else if (cnt == CNT_LAST) state_n = ERR;
      end
      DONE: state_n = IDLE;
      ERR:  stall   = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ld_b   = bus_rdata[8*req_q.lo +: 8];
    ld_h   = bus_rdata[16*req_q.lo[1] +: 16];
    ld_val = bus_rdata;
    case (req_q.size)
      2'b00:   ld_val = {{24{req_q.sign & ld_b[7]}}, ld_b};
      2'b01:   ld_val = {{16{req_q.sign & ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      rdata     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      bus_err   <= 1'b0;
    end else begin
      state   <= state_n;
      bus_req <= (state_n == REQ);
      bus_err <= (state_n == ERR);
      if (accept) begin
        cnt       <= '0;
        req_q     <= '{we: mem_w, size: mem_size, sign: mem_sign, lo: addr[1:0]};
        bus_we    <= mem_w;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= be_c;
        bus_wdata <= wd_c;
      end
      if (state == REQ) begin
        cnt <= cnt + 1'b1;
        if (bus_ack && !req_q.we) rdata <= ld_val;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: word/byte loads, half store,
// misalignment, timeout and reset behaviour.

module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst, cpu_en, mem_r, mem_w, mem_sign, bus_ack;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall, misalign, bus_req, bus_we, bus_err;
  logic [3:0]  bus_be;
  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .mem_r(mem_r), .mem_w(mem_w),
    .mem_size(mem_size), .mem_sign(mem_sign), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .misalign(misalign), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic r, input logic w, input logic [1:0] sz,
                     input logic sg, input logic [31:0] a, input logic [31:0] d);
    mem_r = r; mem_w = w; mem_size = sz; mem_sign = sg; addr = a; wdata = d;
  endtask

  initial begin
    rst = 1; cpu_en = 1; bus_ack = 0; bus_rdata = '0;
    req(0, 0, 2'b00, 0, '0, '0);
    step(); step(); #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_req", {31'b0, bus_req}, 32'h0);
    chk("rst_err", {31'b0, bus_err}, 32'h0);
    chk("rst_be", {28'b0, bus_be}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    rst = 0;
    step();

    // Word load, ack in second REQ cycle
    req(1, 0, 2'b10, 0, 32'h10, 0); #1;
    chk("wl_stall_acc", {31'b0, stall}, 32'h1);
    chk("wl_mis", {31'b0, misalign}, 32'h0);
    step(); #1;
    chk("wl_req", {31'b0, bus_req}, 32'h1);
    chk("wl_addr", bus_addr, 32'h10);
    chk("wl_be", {28'b0, bus_be}, 32'hF);
    chk("wl_we", {31'b0, bus_we}, 32'h0);
    chk("wl_stall_r1", {31'b0, stall}, 32'h1);
    step(); bus_ack = 1; bus_rdata = 32'hDEADBEEF; #1;
    chk("wl_stall_r2", {31'b0, stall}, 32'h1);
    step(); bus_ack = 0; #1;
    chk("wl_rdata", rdata, 32'hDEADBEEF);
    chk("wl_done_stall", {31'b0, stall}, 32'h0);
    chk("wl_done_req", {31'b0, bus_req}, 32'h0);
    step(); req(0, 0, 2'b00, 0, 0, 0);

    // Signed byte load at lane 3
    step(); req(1, 0, 2'b00, 1, 32'h13, 0);
    step(); #1;
    chk("sb_be", {28'b0, bus_be}, 32'h8);
    chk("sb_addr", bus_addr, 32'h10);
    bus_ack = 1; bus_rdata = 32'h80123456;
    step(); bus_ack = 0; #1;
    chk("sb_rdata", rdata, 32'hFFFFFF80);
    step(); req(0, 0, 2'b00, 0, 0, 0);

    // Unsigned byte load, same address
    step(); req(1, 0, 2'b00, 0, 32'h13, 0);
    step(); bus_ack = 1; bus_rdata = 32'h80123456;
    step(); bus_ack = 0; #1;
    chk("ub_rdata", rdata, 32'h00000080);
    step(); req(0, 0, 2'b00, 0, 0, 0);

    // Half store to upper half
    step(); req(0, 1, 2'b01, 0, 32'h22, 32'h1234ABCD);
    step(); #1;
    chk("hs_we", {31'b0, bus_we}, 32'h1);
    chk("hs_be", {28'b0, bus_be}, 32'hC);
    chk("hs_wdata", bus_wdata, 32'hABCDABCD);
    chk("hs_addr", bus_addr, 32'h20);
    bus_ack = 1; bus_rdata = 32'h55555555;
    step(); bus_ack = 0; #1;
    chk("hs_rdata_keep", rdata, 32'h00000080);
    step(); req(0, 0, 2'b00, 0, 0, 0);

    // Misaligned word
    step(); req(1, 0, 2'b10, 0, 32'h05, 0); #1;
    chk("mw_mis", {31'b0, misalign}, 32'h1);
    chk("mw_stall", {31'b0, stall}, 32'h0);
    step(); #1;
    chk("mw_req", {31'b0, bus_req}, 32'h0);
    chk("mw_rdata", rdata, 32'h00000080);
    req(0, 0, 2'b00, 0, 0, 0);

    // Timeout: 4 REQ cycles without ack
    step(); req(1, 0, 2'b10, 0, 32'h40, 0);
    step(); step(); step(); step(); #1;
    chk("to_req4", {31'b0, bus_req}, 32'h1);
    chk("to_err4", {31'b0, bus_err}, 32'h0);
    step(); #1;
    chk("to_err", {31'b0, bus_err}, 32'h1);
    chk("to_stall", {31'b0, stall}, 32'h1);
    chk("to_req_off", {31'b0, bus_req}, 32'h0);
    bus_ack = 1;
    step(); bus_ack = 0; #1;
    chk("to_err_hold", {31'b0, bus_err}, 32'h1);
    chk("to_stall_hold", {31'b0, stall}, 32'h1);
    rst = 1; req(0, 0, 2'b00, 0, 0, 0);
    step(); rst = 0; #1;
    chk("to_rst_err", {31'b0, bus_err}, 32'h0);
    chk("to_rst_stall", {31'b0, stall}, 32'h0);

    // Reset mid-REQ, then cpu_en low
    step(); req(1, 0, 2'b10, 0, 32'h80, 0);
    step(); #1;
    chk("rr_req", {31'b0, bus_req}, 32'h1);
    rst = 1;
    step(); rst = 0; cpu_en = 0; #1;
    chk("rr_req_off", {31'b0, bus_req}, 32'h0);
    chk("rr_stall_en0", {31'b0, stall}, 32'h0);
    chk("rr_mis_en0", {31'b0, misalign}, 32'h0);
    step(); #1;
    chk("rr_noacc", {31'b0, bus_req}, 32'h0);
    chk("rr_stall2", {31'b0, stall}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage directly downstream of the single-cycle data path.
- Consumes ALU_out (effective address) and Data_out (rt store data), and returns Data_in (load data).
- Drives a req/ack data-memory bus and handles byte/half/word sizing, alignment checks, stall generation and bus timeout.
- While an access is outstanding, the top level gates the data path's cpu_en with ~stall.

Parameters:
TIMEOUT, 255, max REQ cycles without bus_ack before declaring a bus error
TIMEOUT_W, 8, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset (driven from cpu_rst)
cpu_en  in  1  CPU enable; new accesses are accepted only when high
mem_r  in  1  load request from controller
mem_w  in  1  store request from controller; has priority over mem_r if both are high
mem_size  in  2  00 byte, 01 half, 10/11 word
mem_sign  in  1  1 = sign-extend byte/half loads, 0 = zero-extend
addr  in  32  effective address (data path ALU_out)
wdata  in  32  store data (data path Data_out)
rdata  out  32  load result (data path Data_in)
stall  out  1  hold CPU (PC and register write) this cycle
misalign  out  1  misaligned access flagged this cycle
bus_req  out  1  bus request
bus_we  out  1  1 = write
bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
bus_be  out  4  byte enables, bit i = byte lane bits[8i+7:8i]
bus_rdata  in  32  bus read data, valid with bus_ack
bus_ack  in  1  one-cycle completion strobe
bus_err  out  1  sticky timeout error

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - State goes to IDLE; timeout counter is cleared.
  - rdata, bus_addr, bus_wdata, bus_be and bus_err are set to 0; bus_req and bus_we go to 0.
  - Any outstanding transaction is abandoned, even mid-REQ.
- Byte ordering is little-endian; the lane index is addr[1:0].
- Valid access = cpu_en & (mem_r | mem_w) in IDLE.
- Alignment rules:
  - Half is misaligned when addr[0]=1.
  - Word is misaligned when addr[1:0]≠0.
  - A misaligned valid access sets misalign=1 combinationally, issues no bus request and gives stall=0; the instruction retires without a memory effect.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
- Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- FSM IDLE:
  - A valid aligned access gives stall=1 combinationally in the same cycle.
  - Address, be, wdata and we are registered at the edge, then go to REQ.
  - With cpu_en=0 nothing is accepted.
- FSM REQ:
  - bus_req=1 and stall=1; bus_addr, bus_be, bus_wdata and bus_we are held stable.
  - The counter increments each cycle.
  - On bus_ack: for a load, the selected lane is captured, extended to 32 bits per mem_sign and registered into rdata; then go to DONE.
  - When the counter reaches TIMEOUT without ack: go to ERR.
  - An ack in the same cycle as the timeout wins.
  - cpu_en=0 during REQ does not abort the transaction.
- FSM DONE:
  - stall=0 and bus_req=0; the CPU advances on this edge and the register file writes rdata.
  - Unconditional transition to IDLE; no new access is accepted in DONE, because the same instruction is still presented.
- FSM ERR:
  - bus_err=1 and stall=1 persist until rst; bus_req=0.
- rdata holds the last completed load value and is unchanged by stores and misaligned accesses.
- Latency: with ack in the first REQ cycle, an access occupies 3 cycles (accept, REQ, DONE).
- bus_ack outside REQ is ignored.
- stall is a combinational function of state and inputs; all bus outputs are registered.

Test Plan:
- Word load:
  - Stimulus: addr=0x0000_0010, mem_r=1, size=10; ack after 2 REQ cycles with bus_rdata=0xDEAD_BEEF.
  - Required: bus_addr=0x10, be=1111, stall high for 3 cycles, rdata=0xDEADBEEF in DONE.
- Signed and unsigned byte load:
  - Stimulus: addr=0x13, bus_rdata=0x80xx_xxxx.
  - Required: be=1000; mem_sign=1 gives rdata=0xFFFF_FF80; mem_sign=0 gives rdata=0x0000_0080.
- Half store:
  - Stimulus: addr=0x22, wdata=0x1234_ABCD, mem_w=1, size=01.
  - Required: bus_we=1, be=1100, bus_wdata=0xABCD_ABCD, rdata unchanged.
- Misaligned word:
  - Stimulus: addr=0x05, size=10.
  - Required: misalign=1, stall=0, bus_req never asserted.
- Timeout:
  - Stimulus: TIMEOUT=4, no ack.
  - Required: ERR after 4 REQ cycles; bus_err=1 and stall=1 held; rst clears both next edge.
- Reset mid-REQ and cpu_en:
  - Stimulus: rst=1 during REQ; then cpu_en=0 with mem_r=1.
  - Required: bus_req=0 the cycle after the rst edge and state is IDLE; with cpu_en=0 no access is accepted and stall=0.
